// File: rtl/fast_square_sweep_ctrl.sv
// Frequency-sweep sequencer for the baseband comb/decimate chain: retune, flush, settle, record, advance.
// Optional build macro FAST_SQUARE_SWEEP_LOOP_EN repeats the sweep forever and adds a sweep_count output.
module fast_square_sweep_ctrl #(
  parameter int NUM_STEPS      = 32,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_STROBES = 202,
  parameter int RECORD_STROBES = 256,
  parameter int ACK_TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        retune_ack,
  input  logic        dp_strobe,
  output logic        dp_reset,
  output logic        freq_step,
  output logic        record,
  output logic [15:0] step_index,
  output logic        busy,
  output logic        done,
  output logic        error,
`ifdef FAST_SQUARE_SWEEP_LOOP_EN
  output logic [15:0] sweep_count,
`endif
  output logic [2:0]  state_dbg
);

  localparam int SMAX = (SETTLE_STROBES > RECORD_STROBES) ? SETTLE_STROBES : RECORD_STROBES;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int CMAX = (ACK_TIMEOUT > FLUSH_CYCLES) ? ACK_TIMEOUT : FLUSH_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RETUNE = 3'd1,
    S_FLUSH  = 3'd2,
    S_SETTLE = 3'd3,
    S_RECORD = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_ccnt;
  logic [SW-1:0] r_scnt;
  logic [15:0]   r_step;
  logic          r_dp_reset;
  logic          r_freq_step;
  logic          r_record;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
`ifdef FAST_SQUARE_SWEEP_LOOP_EN
  logic [15:0]   r_sweep_count;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ccnt      <= '0;
      r_scnt      <= '0;
      r_step      <= '0;
      r_dp_reset  <= 1'b0;
      r_freq_step <= 1'b0;
      r_record    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef FAST_SQUARE_SWEEP_LOOP_EN
      r_sweep_count <= '0;
`endif
    end else if (abort && (r_state != S_IDLE)) begin
      // Abort outranks every terminal event; one flush pulse leaves the chain clean.
      r_state     <= S_IDLE;
      r_ccnt      <= '0;
      r_scnt      <= '0;
      r_dp_reset  <= 1'b1;
      r_freq_step <= 1'b0;
      r_record    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_freq_step <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dp_reset <= 1'b0;
          if (start && !abort) begin
            r_step      <= '0;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            r_freq_step <= 1'b1;
            r_ccnt      <= '0;
            r_state     <= S_RETUNE;
`ifdef FAST_SQUARE_SWEEP_LOOP_EN
            r_sweep_count <= '0;
`endif
          end
        end
        S_RETUNE: begin
          // r_freq_step marks the first cycle, where a stale ack must not count.
          if (!r_freq_step && retune_ack) begin
            r_dp_reset <= 1'b1;
            r_ccnt     <= '0;
            r_state    <= S_FLUSH;
          end else if (r_ccnt == CW'(ACK_TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_ccnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_ccnt <= r_ccnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_ccnt == CW'(FLUSH_CYCLES - 1)) begin
            r_dp_reset <= 1'b0;
            r_ccnt     <= '0;
            r_scnt     <= '0;
            r_state    <= S_SETTLE;
          end else begin
            r_ccnt <= r_ccnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (dp_strobe) begin
            if (r_scnt == SW'(SETTLE_STROBES - 1)) begin
              r_record <= 1'b1;
              r_scnt   <= '0;
              r_state  <= S_RECORD;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        S_RECORD: begin
          if (dp_strobe) begin
            if (r_scnt == SW'(RECORD_STROBES - 1)) begin
              r_record <= 1'b0;
              r_scnt   <= '0;
              r_state  <= S_NEXT;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        S_NEXT: begin
          if (r_step == 16'(NUM_STEPS - 1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
`ifdef FAST_SQUARE_SWEEP_LOOP_EN
            r_sweep_count <= r_sweep_count + 16'd1;
`endif
          end else begin
            r_step      <= r_step + 16'd1;
            r_freq_step <= 1'b1;
            r_ccnt      <= '0;
            r_state     <= S_RETUNE;
          end
        end
        S_DONE: begin
`ifdef FAST_SQUARE_SWEEP_LOOP_EN
          r_step      <= '0;
          r_freq_step <= 1'b1;
          r_ccnt      <= '0;
          r_state     <= S_RETUNE;
`else
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`endif
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dp_reset   = r_dp_reset;
  assign freq_step  = r_freq_step;
  assign record     = r_record;
  assign step_index = r_step;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign state_dbg  = r_state;
`ifdef FAST_SQUARE_SWEEP_LOOP_EN
  assign sweep_count = r_sweep_count;
`endif

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed bench for fast_square_sweep_ctrl: 3 steps, 2-cycle flush, 4 settle / 5 record strobes, strobe every 17 cycles.
// Build with FAST_SQUARE_SWEEP_LOOP_EN defined to exercise the repeating-sweep variant.
module tb_fast_square_sweep_ctrl;

  localparam int NOM_DUR = 456;  // cycles from start to done when start is issued at strobe phase 5

  logic        clock = 1'b0;
  logic        reset, start, abort, retune_ack, dp_strobe;
  logic        dp_reset, freq_step, record, busy, done, error;
  logic [15:0] step_index;
  logic [2:0]  state_dbg;
`ifdef FAST_SQUARE_SWEEP_LOOP_EN
  logic [15:0] sweep_count;
`endif

  fast_square_sweep_ctrl #(
    .NUM_STEPS(3), .FLUSH_CYCLES(2), .SETTLE_STROBES(4), .RECORD_STROBES(5), .ACK_TIMEOUT(10)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .retune_ack(retune_ack), .dp_strobe(dp_strobe),
    .dp_reset(dp_reset), .freq_step(freq_step), .record(record),
    .step_index(step_index), .busy(busy), .done(done), .error(error),
`ifdef FAST_SQUARE_SWEEP_LOOP_EN
    .sweep_count(sweep_count),
`endif
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // strobe source: one dp_strobe every 17 cycles, phase visible in sph
  int sph = 0;
  initial begin
    dp_strobe = 1'b0;
    forever begin
      @(posedge clock); #1;
      sph = (sph == 16) ? 0 : sph + 1;
      dp_strobe = (sph == 0);
    end
  end

  // synth model: ack pulse 3 cycles after freq_step
  logic ack_en = 1'b1;
  initial begin
    retune_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && freq_step && ack_en) begin
        repeat (3) @(posedge clock);
        #1 retune_ack = 1'b1;
        @(posedge clock);
        #1 retune_ack = 1'b0;
      end
    end
  end

  // monitor / scoreboard collection
  logic [15:0] fs_q[$];
  int          dpr_q[$];
  int          rec_q[$];
  logic [15:0] exp_q[$];
  int dpr_len = 0, win = 0, n_done = 0, n_busy_fall = 0;
  int fs_cyc = 0, done_cyc = 0, busy_fall_cyc = 0, err_cyc = 0, start_cyc = 0;
  logic prev_rec = 1'b0, prev_busy = 1'b0, prev_err = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        dpr_len = 0; win = 0;
        prev_rec = 1'b0; prev_busy = 1'b0; prev_err = 1'b0;
      end else begin
        if (freq_step) begin fs_q.push_back(step_index); fs_cyc = cyc; end
        if (dp_reset) dpr_len++;
        else if (dpr_len > 0) begin dpr_q.push_back(dpr_len); dpr_len = 0; end
        if (record && dp_strobe) win++;
        if (prev_rec && !record) begin rec_q.push_back(win); win = 0; end
        if (done) begin n_done++; done_cyc = cyc; end
        if (prev_busy && !busy) begin n_busy_fall++; busy_fall_cyc = cyc; end
        if (error && !prev_err) err_cyc = cyc;
        prev_rec = record; prev_busy = busy; prev_err = error;
      end
    end
  end

  // driver tasks
  task automatic at_neg();
    @(negedge clock); #1;
  endtask

  task automatic clear_stats();
    fs_q.delete(); dpr_q.delete(); rec_q.delete();
    n_done = 0; n_busy_fall = 0; done_cyc = 0; busy_fall_cyc = 0; err_cyc = 0; fs_cyc = 0;
  endtask

  task automatic pulse_start();
    @(posedge clock); #2 start = 1'b1;
    @(posedge clock); #2 start = 1'b0;
  endtask

  // issue start at strobe phase 5 so sweep timing is repeatable
  task automatic start_sweep();
    int n = 0;
    do begin
      @(posedge clock); #2; n++;
    end while (sph != 5 && n < 40);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clock); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int max_cyc);
    int i = 0;
    while (n_done < target && i < max_cyc) begin at_neg(); i++; end
    if (n_done < target) check($sformatf("%s_done_timeout", tag), 0, 1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input logic [15:0] idx, input int max_cyc);
    int i = 0;
    while (!(state_dbg == st && step_index == idx) && i < max_cyc) begin at_neg(); i++; end
    if (!(state_dbg == st && step_index == idx)) check($sformatf("%s_state_timeout", tag), 0, 1);
  endtask

  task automatic check_sweep(input string tag);
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(16'(k));
    check($sformatf("%s_fs_count", tag), fs_q.size(), 3);
    while (exp_q.size() > 0 && fs_q.size() > 0)
      check($sformatf("%s_fs_step", tag), fs_q.pop_front(), exp_q.pop_front());
    check($sformatf("%s_flush_runs", tag), dpr_q.size(), 3);
    foreach (dpr_q[k]) check($sformatf("%s_flush_len%0d", tag, k), dpr_q[k], 2);
    check($sformatf("%s_rec_windows", tag), rec_q.size(), 3);
    foreach (rec_q[k]) check($sformatf("%s_rec_strobes%0d", tag, k), rec_q[k], 5);
    check($sformatf("%s_done_count", tag), n_done, 1);
    check($sformatf("%s_duration", tag), done_cyc - start_cyc, NOM_DUR);
    check($sformatf("%s_busy_fall", tag), busy_fall_cyc - done_cyc, 1);
    check($sformatf("%s_step_hold", tag), step_index, 2);
    check($sformatf("%s_error", tag), error, 0);
  endtask

  task automatic do_abort();
    @(posedge clock); #2 abort = 1'b1;
    @(posedge clock); #2 abort = 1'b0;
  endtask

  // scenarios
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clock);
    at_neg();
    check("rst_outs", {dp_reset, freq_step, record, busy, done, error}, 0);
    check("rst_step", step_index, 0);
    check("rst_state", state_dbg, 0);
    @(posedge clock); #2 reset = 1'b0;
    repeat (3) at_neg();

`ifdef FAST_SQUARE_SWEEP_LOOP_EN
    clear_stats();
    start_sweep();
    wait_done("loop1", 1, 2000);
    check("loop_count1", sweep_count, 1);
    wait_done("loop2", 2, 2000);
    check("loop_count2", sweep_count, 2);
    check("loop_done_pulses", n_done, 2);
    check("loop_busy", busy, 1);
    check("loop_busy_drops", n_busy_fall, 0);
    repeat (20) at_neg();
    do_abort();
    at_neg();
    check("loop_abort_busy", busy, 0);
    check("loop_abort_state", state_dbg, 0);
    check("loop_abort_count", sweep_count, 2);
    check("loop_abort_flush", dp_reset, 1);
`else
    // nominal sweep
    clear_stats();
    start_sweep();
    wait_done("nom", 1, 2000);
    repeat (2) at_neg();
    check_sweep("nom");

    // start pulses while busy must not disturb the sweep
    clear_stats();
    start_sweep();
    repeat (30) at_neg();
    pulse_start();
    repeat (200) at_neg();
    pulse_start();
    wait_done("busy_start", 1, 2000);
    repeat (2) at_neg();
    check_sweep("busy_start");

    // ack timeout
    clear_stats();
    ack_en = 1'b0;
    start_sweep();
    begin
      int i = 0;
      while (!error && i < 50) begin at_neg(); i++; end
    end
    check("to_error", error, 1);
    check("to_latency", err_cyc - fs_cyc, 10);
    check("to_state", state_dbg, 0);
    check("to_busy", busy, 0);
    repeat (5) at_neg();
    check("to_no_done", n_done, 0);
    check("to_no_flush", dpr_q.size() + dpr_len, 0);
    check("to_error_sticky", error, 1);
    ack_en = 1'b1;
    clear_stats();
    start_sweep();
    at_neg();
    check("to_error_cleared", error, 0);
    wait_done("to_rerun", 1, 2000);
    repeat (2) at_neg();
    check_sweep("to_rerun");

    // abort in RECORD of step 1
    clear_stats();
    start_sweep();
    wait_state("ab", 3'd4, 16'd1, 2000);
    repeat (20) at_neg();
    do_abort();
    at_neg();
    check("ab_record", record, 0);
    check("ab_dp_reset", dp_reset, 1);
    check("ab_freq_step", freq_step, 0);
    check("ab_busy", busy, 0);
    check("ab_state", state_dbg, 0);
    check("ab_step", step_index, 1);
    at_neg();
    check("ab_dp_reset_one", dp_reset, 0);
    repeat (40) at_neg();
    check("ab_no_done", n_done, 0);
    check("ab_error", error, 0);
    check("ab_fs_count", fs_q.size(), 2);
    check("ab_step_hold", step_index, 1);

    // start together with abort in IDLE
    clear_stats();
    @(posedge clock); #2 start = 1'b1; abort = 1'b1;
    @(posedge clock); #2 start = 1'b0; abort = 1'b0;
    repeat (3) at_neg();
    check("sa_busy", busy, 0);
    check("sa_state", state_dbg, 0);
    check("sa_fs_count", fs_q.size(), 0);

    // reset mid-SETTLE, then a full sweep
    clear_stats();
    start_sweep();
    wait_state("rs", 3'd3, 16'd0, 500);
    at_neg();
    @(posedge clock); #2 reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
    at_neg();
    check("rs_outs", {dp_reset, freq_step, record, busy, done, error}, 0);
    check("rs_step", step_index, 0);
    check("rs_state", state_dbg, 0);
    repeat (3) at_neg();
    check("rs_no_flush", dp_reset, 0);
    clear_stats();
    start_sweep();
    wait_done("rs_rerun", 1, 2000);
    repeat (2) at_neg();
    check_sweep("rs_rerun");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    check("watchdog", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
